// File: rtl/tx_chan_arbiter_pkg.sv
// Shared definitions for the tx channel arbiter: data word width and FSM state encoding.
package tx_chan_arbiter_pkg;

  localparam int DATA_MSB = 7;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_WAIT = WAIT,
    S_DONE = DONE
  } arb_state_t;

endpackage

// File: rtl/tx_chan_arbiter_if.sv
// Requester / tx-side bundle of the tx channel arbiter.
// slave = arbiter side, master = producers plus tx block.
interface tx_chan_arbiter_if #(
  parameter int NREQ     = 4,
  parameter int DATA_MSB = tx_chan_arbiter_pkg::DATA_MSB
) ();

  logic [NREQ-1:0]              req_v;
  logic [NREQ*(DATA_MSB+1)-1:0] req_data;
  logic [NREQ-1:0]              req_done;
  logic [NREQ-1:0]              gnt;
  logic                         vi;
  logic [DATA_MSB:0]            sdata;
  logic                         snt;
  logic                         busy;
  logic                         err;

  modport slave (
    input  req_v, req_data, snt,
    output req_done, gnt, vi, sdata, busy, err
  );

  modport master (
    output req_v, req_data, snt,
    input  req_done, gnt, vi, sdata, busy, err
  );

endinterface

// File: rtl/tx_chan_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index after i_last, wrapping modulo NREQ.
module tx_chan_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req_v,
  input  logic [IW-1:0]   i_last,
  output logic [IW-1:0]   o_pick,
  output logic            o_any_v
);

  // w_cand[gi] is the index at distance gi+1 from the last winner.
  logic [IW-1:0]   w_cand [NREQ];
  logic [NREQ-1:0] w_hit;

  genvar gi;
  for (gi = 0; gi < NREQ; gi++) begin : g_cand
    assign w_cand[gi] = IW'((int'(i_last) + gi + 1) % NREQ);
    assign w_hit[gi]  = i_req_v[w_cand[gi]];
  end

  // Scan farthest to nearest so the nearest valid candidate wins.
  always_comb begin
    o_pick  = '0;
    o_any_v = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        o_pick  = w_cand[k];
        o_any_v = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_chan_arbiter.sv
// Round-robin arbiter sharing one 4-phase tx channel between NREQ requesters.
// Optional watchdog on the snt wait enabled by defining TXARB_TIMEOUT_EN.
module tx_chan_arbiter
  import tx_chan_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DATA_MSB  = tx_chan_arbiter_pkg::DATA_MSB,
  parameter int TO_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  tx_chan_arbiter_if.slave  bus
);

  localparam int IW = $clog2(NREQ);
  localparam int W  = DATA_MSB + 1;

  if (NREQ < 2 || NREQ > 8 || TO_CYCLES < 1 ||
      DATA_MSB != tx_chan_arbiter_pkg::DATA_MSB) begin : g_bad_cfg
    $error("tx_chan_arbiter: illegal NREQ/TO_CYCLES or DATA_MSB differs from package");
  end

  arb_state_t      r_state;
  logic [IW-1:0]   r_last;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_req_done;
  logic            r_vi;
  logic [W-1:0]    r_sdata;
  logic            r_busy;

  logic [IW-1:0]   w_pick;
  logic            w_any_v;
  logic [NREQ-1:0] w_pick_oh;
  logic [W-1:0]    w_words [NREQ];

  tx_chan_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .i_req_v (bus.req_v),
    .i_last  (r_last),
    .o_pick  (w_pick),
    .o_any_v (w_any_v)
  );

  genvar gi;
  for (gi = 0; gi < NREQ; gi++) begin : g_lane
    assign w_words[gi]   = bus.req_data[gi*W +: W];
    assign w_pick_oh[gi] = (w_pick == IW'(gi));
  end

`ifdef TXARB_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);
  logic [CW-1:0] r_to_cnt;
  logic          r_err;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_last     <= IW'(NREQ - 1);
      r_gnt      <= '0;
      r_req_done <= '0;
      r_vi       <= 1'b0;
      r_sdata    <= '0;
      r_busy     <= 1'b0;
`ifdef TXARB_TIMEOUT_EN
      r_to_cnt   <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_vi       <= 1'b0;
      r_req_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any_v) begin
            r_gnt   <= w_pick_oh;
            r_sdata <= w_words[w_pick];
            r_vi    <= 1'b1;
            r_last  <= w_pick;
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
`ifdef TXARB_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
          end
`ifdef TXARB_TIMEOUT_EN
          if (bus.snt) r_err <= 1'b1;
`endif
        end
        S_WAIT: begin
          if (bus.snt) begin
            r_req_done <= r_gnt;
            r_gnt      <= '0;
            r_state    <= S_DONE;
          end
`ifdef TXARB_TIMEOUT_EN
          // A 4-phase handshake cannot be aborted, so only flag and keep waiting.
          else begin
            if (r_to_cnt != CW'(TO_CYCLES)) r_to_cnt <= r_to_cnt + 1'b1;
            if (r_to_cnt == CW'(TO_CYCLES - 1)) r_err <= 1'b1;
          end
`endif
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.req_done = r_req_done;
  assign bus.vi       = r_vi;
  assign bus.sdata    = r_sdata;
  assign bus.busy     = r_busy;
`ifdef TXARB_TIMEOUT_EN
  assign bus.err      = r_err;
`else
  assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_tx_chan_arbiter.sv
// Directed bench for tx_chan_arbiter (NREQ=4, DATA_MSB=7, TO_CYCLES=16).
// Timeout checks are included when TXARB_TIMEOUT_EN is defined.
module tb_tx_chan_arbiter;

`ifdef TXARB_TIMEOUT_EN
  localparam logic ERR_ON_SPURIOUS = 1'b1;
`else
  localparam logic ERR_ON_SPURIOUS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  tx_chan_arbiter_if #(.NREQ(4), .DATA_MSB(7)) bus ();

  tx_chan_arbiter #(
    .NREQ      (4),
    .DATA_MSB  (7),
    .TO_CYCLES (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    bus.req_v = '0;
    bus.snt  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Wait for vi, check grant/data, return snt five cycles later, check done pulse.
  task automatic serve(input int idx, input logic [7:0] exp_data);
    int n;
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    n  = 0;
    do begin
      tick();
      n++;
    end while (!bus.vi && n < 8);
    chk("vi_seen", {31'd0, bus.vi}, 32'd1);
    chk($sformatf("gnt_req%0d", idx), {28'd0, bus.gnt}, {28'd0, oh});
    chk($sformatf("sdata_req%0d", idx), {24'd0, bus.sdata}, {24'd0, exp_data});
    repeat (4) tick();
    chk("gnt_held", {28'd0, bus.gnt}, {28'd0, oh});
    chk("vi_low", {31'd0, bus.vi}, 32'd0);
    bus.snt = 1'b1;
    tick();
    bus.snt = 1'b0;
    chk($sformatf("done_req%0d", idx), {28'd0, bus.req_done}, {28'd0, oh});
    chk("gnt_clr", {28'd0, bus.gnt}, 32'd0);
    tick();
    chk("done_pulse_end", {28'd0, bus.req_done}, 32'd0);
    $display("xfer req=%0d data=%02h", idx, exp_data);
  endtask

  initial begin
    bus.req_v    = '0;
    bus.req_data = '0;
    bus.snt      = 1'b0;

    // Reset state
    do_reset();
    #1;
    chk("rst_gnt",  {28'd0, bus.gnt},      32'd0);
    chk("rst_vi",   {31'd0, bus.vi},       32'd0);
    chk("rst_busy", {31'd0, bus.busy},     32'd0);
    chk("rst_err",  {31'd0, bus.err},      32'd0);
    chk("rst_done", {28'd0, bus.req_done}, 32'd0);
    chk("rst_sdata", {24'd0, bus.sdata},   32'd0);

    // Single requester 2, one-cycle latency to vi
    bus.req_data = 32'h00A5_0000;
    bus.req_v    = 4'b0100;
    tick();
    chk("r2_vi",    {31'd0, bus.vi},   32'd1);
    chk("r2_gnt",   {28'd0, bus.gnt},  32'h4);
    chk("r2_sdata", {24'd0, bus.sdata}, 32'hA5);
    chk("r2_busy",  {31'd0, bus.busy}, 32'd1);
    tick();
    chk("r2_vi_drop", {31'd0, bus.vi}, 32'd0);
    chk("r2_gnt_hold", {28'd0, bus.gnt}, 32'h4);
    bus.snt = 1'b1;
    tick();
    bus.snt = 1'b0;
    bus.req_v = 4'b0000;
    chk("r2_done", {28'd0, bus.req_done}, 32'h4);
    chk("r2_busy_done", {31'd0, bus.busy}, 32'd1);
    tick();
    chk("r2_idle_busy", {31'd0, bus.busy}, 32'd0);
    chk("r2_done_end", {28'd0, bus.req_done}, 32'd0);
    $display("xfer req=2 data=a5");

    // Fairness with all four valid after reset: 0,1,2,3,0
    do_reset();
    bus.req_data = 32'h1312_1110;
    bus.req_v    = 4'b1111;
    serve(0, 8'h10);
    serve(1, 8'h11);
    serve(2, 8'h12);
    serve(3, 8'h13);
    serve(0, 8'h10);

    // Spurious snt while idle
    bus.req_v = 4'b0000;
    tick();
    tick();
    bus.snt = 1'b1;
    tick();
    bus.snt = 1'b0;
    chk("sp_done", {28'd0, bus.req_done}, 32'd0);
    chk("sp_busy", {31'd0, bus.busy}, 32'd0);
    chk("sp_vi",   {31'd0, bus.vi},   32'd0);
    tick();
    chk("sp_err",  {31'd0, bus.err},  {31'd0, ERR_ON_SPURIOUS});
    chk("sp_busy2", {31'd0, bus.busy}, 32'd0);

    // Asynchronous reset in WAIT with requester 1 granted
    do_reset();
    bus.req_data = 32'h4433_2211;
    bus.req_v    = 4'b0010;
    tick();
    chk("ar_gnt", {28'd0, bus.gnt}, 32'h2);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_gnt0",   {28'd0, bus.gnt},   32'd0);
    chk("ar_vi0",    {31'd0, bus.vi},    32'd0);
    chk("ar_busy0",  {31'd0, bus.busy},  32'd0);
    chk("ar_sdata0", {24'd0, bus.sdata}, 32'd0);
    chk("ar_err0",   {31'd0, bus.err},   32'd0);
    @(negedge clk);
    reset_n   = 1'b1;
    bus.req_v = 4'b0011;
    tick();
    chk("ar_regnt", {28'd0, bus.gnt}, 32'h1);
    chk("ar_sdata", {24'd0, bus.sdata}, 32'h11);
    bus.snt = 1'b1;
    tick();
    bus.snt = 1'b0;
    chk("ar_done", {28'd0, bus.req_done}, 32'h1);
    $display("xfer req=0 data=11");

    // Requester 3 withdraws before its turn
    do_reset();
    bus.req_data = 32'hD3C2_B1A0;
    bus.req_v    = 4'b1111;
    serve(0, 8'hA0);
    bus.req_v = 4'b0111;
    serve(1, 8'hB1);
    serve(2, 8'hC2);
    serve(0, 8'hA0);

`ifdef TXARB_TIMEOUT_EN
    // Watchdog: err after 16 WAIT cycles, FSM holds, late snt completes
    do_reset();
    bus.req_data = 32'h0000_005A;
    bus.req_v    = 4'b0001;
    tick();
    chk("to_vi", {31'd0, bus.vi}, 32'd1);
    repeat (15) tick();
    chk("to_err_pre", {31'd0, bus.err}, 32'd0);
    tick();
    chk("to_err", {31'd0, bus.err}, 32'd1);
    chk("to_busy", {31'd0, bus.busy}, 32'd1);
    chk("to_gnt", {28'd0, bus.gnt}, 32'h1);
    bus.snt = 1'b1;
    tick();
    bus.snt = 1'b0;
    chk("to_done", {28'd0, bus.req_done}, 32'h1);
    chk("to_err_sticky", {31'd0, bus.err}, 32'd1);
    $display("xfer req=0 data=5a");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
